operand_entry_fsm: RTL and testbench

- Upstream stage of the 4-bit adder/BCD display datapath; produces its `x` and `y` operands.
- The user sets a value on four slide switches, then presses one push button. Each press is debounced and edge-detected.
- The first press latches X and the second latches Y. The third press returns to the X-entry state.
- A `valid` flag tells the downstream adder/display stage when both operands are committed.

---
 rtl/operand_entry_fsm.sv | 115 +++++++++++
 tb/tb_operand_entry_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/operand_entry_fsm.sv
// Operand entry front-end: synchronizes switches and a bouncy push button,
// debounces the button, and steps an X/Y/SHOW capture FSM on each press.
module operand_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       key_n,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       valid,
    output logic [1:0] state,
    output logic       press
);

    typedef enum logic [1:0] {
        LOAD_X = 2'b00,
        LOAD_Y = 2'b01,
        SHOW   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       sw_m_r;
    logic [3:0]       sw_s;
    logic             key_m_r;
    logic             key_s;
    logic             db_level_r;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;

    // Two-flop synchronizers for the asynchronous switch and button inputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw_m_r  <= 4'd0;
            sw_s    <= 4'd0;
            key_m_r <= 1'b1;
            key_s   <= 1'b1;
        end else begin
            sw_m_r  <= sw;
            sw_s    <= sw_m_r;
            key_m_r <= key_n;
            key_s   <= key_m_r;
        end
    end

    // Debounce counter and accepted level; press fires on the accepted 1->0 change.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            db_level_r <= 1'b1;
            cnt_r      <= '0;
            press      <= 1'b0;
        end else begin
            if (key_s == db_level_r) begin
                cnt_r <= '0;
                press <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                db_level_r <= key_s;
                cnt_r      <= '0;
                press      <= ~key_s;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
                press <= 1'b0;
            end
        end
    end

    // Operand capture FSM; the unused encoding recovers to LOAD_X.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD_X;
            x       <= 4'd0;
            y       <= 4'd0;
            valid   <= 1'b0;
        end else begin
            case (state_r)
                LOAD_X: begin
                    if (press) begin
                        x       <= sw_s;
                        state_r <= LOAD_Y;
                    end else begin
                        state_r <= LOAD_X;
                    end
                end
                LOAD_Y: begin
                    if (press) begin
                        y       <= sw_s;
                        valid   <= 1'b1;
                        state_r <= SHOW;
                    end else begin
                        state_r <= LOAD_Y;
                    end
                end
                SHOW: begin
                    if (press) begin
                        valid   <= 1'b0;
                        state_r <= LOAD_X;
                    end else begin
                        state_r <= SHOW;
                    end
                end
                default: begin
                    valid   <= 1'b0;
                    state_r <= LOAD_X;
                end
            endcase
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm: a model pushes expected {x,y,valid,state}
// per press, and a negedge monitor pops and compares on every output change.
module tb_operand_entry_fsm;

    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       key_n = 1'b1;
    logic [3:0] x;
    logic [3:0] y;
    logic       valid;
    logic [1:0] state;
    logic       press;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int press_cnt = 0;
    int last_change_cyc = 0;
    int press_start = 0;

    logic [10:0] exp_q[$];
    logic [10:0] prev = 11'd0;
    logic [3:0]  m_x = 4'd0;
    logic [3:0]  m_y = 4'd0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_state = 2'b00;

    operand_entry_fsm #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .sw(sw), .key_n(key_n),
        .x(x), .y(y), .valid(valid), .state(state), .press(press)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every change of the observable outputs must match the next expectation.
    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        if (press === 1'b1) press_cnt++;
        cur = {x, y, valid, state};
        if (!rst_n) begin
            prev = cur;
        end else if (cur !== prev) begin
            last_change_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_change", 32'(cur), 32'(prev));
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", 32'(cur), 32'(e));
            end
            prev = cur;
        end
    end

    task automatic model_press(input logic [3:0] v);
        case (m_state)
            2'b00: begin m_x = v; m_state = 2'b01; end
            2'b01: begin m_y = v; m_valid = 1'b1; m_state = 2'b10; end
            default: begin m_valid = 1'b0; m_state = 2'b00; end
        endcase
        exp_q.push_back({m_x, m_y, m_valid, m_state});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_press(input logic [3:0] v, input int hold);
        @(posedge clk); #1;
        sw = v;
        key_n = 1'b0;
        press_start = cyc + 1;
        model_press(v);
        repeat (hold) @(posedge clk);
        #1 key_n = 1'b1;
        repeat (20) @(posedge clk);
        wait_drain("drain");
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                                 input logic ev, input logic [1:0] es);
        #1;
        check({tag, "_x"}, 32'(x), 32'(ex));
        check({tag, "_y"}, 32'(y), 32'(ey));
        check({tag, "_valid"}, 32'(valid), 32'(ev));
        check({tag, "_state"}, 32'(state), 32'(es));
    endtask

    initial begin
        int pc;
        int lat;
        repeat (3) @(posedge clk);
        #5 rst_n = 1'b1;

        // 1: idle after reset
        repeat (50) @(posedge clk);
        check_outputs("reset", 4'd0, 4'd0, 1'b0, 2'b00);
        check("reset_no_press", 32'(press_cnt), 32'd0);

        // 2: two clean presses, 9 then 7
        do_press(4'd9, 20);
        lat = last_change_cyc - press_start;
        check("latency_in_window", 32'((lat >= DC + 1) && (lat <= DC + 3)), 32'd1);
        check_outputs("load_x", 4'd9, 4'd0, 1'b0, 2'b01);
        do_press(4'd7, 20);
        check_outputs("load_y", 4'd9, 4'd7, 1'b1, 2'b10);
        check("sum", 32'({1'b0, x} + {1'b0, y}), 32'd16);
        check("press_count_2", 32'(press_cnt), 32'd2);

        // 3: short bounces must be rejected
        pc = press_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 key_n = 1'b0;
            repeat (3) @(posedge clk); #1 key_n = 1'b1;
            repeat (2) @(posedge clk);
        end
        repeat (30) @(posedge clk);
        check("bounce_no_press", 32'(press_cnt - pc), 32'd0);
        check_outputs("bounce", 4'd9, 4'd7, 1'b1, 2'b10);

        // 4: long hold gives one strobe, SHOW -> LOAD_X
        pc = press_cnt;
        do_press(4'd4, 200);
        check("hold_one_press", 32'(press_cnt - pc), 32'd1);
        check_outputs("hold", 4'd9, 4'd7, 1'b0, 2'b00);

        // 5: SHOW with 15/15, then wrap and reload X
        do_press(4'd15, 20);
        do_press(4'd15, 20);
        check_outputs("show_ff", 4'd15, 4'd15, 1'b1, 2'b10);
        do_press(4'd1, 20);
        check_outputs("show_exit", 4'd15, 4'd15, 1'b0, 2'b00);
        do_press(4'd3, 20);
        check_outputs("reload_x", 4'd3, 4'd15, 1'b0, 2'b01);

        // 6: asynchronous reset while in LOAD_Y with x = 12
        do_press(4'd5, 20);
        do_press(4'd0, 20);
        do_press(4'd12, 20);
        check_outputs("pre_reset", 4'd12, 4'd5, 1'b0, 2'b01);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #2;
        check("async_x", 32'(x), 32'd0);
        check("async_state", 32'(state), 32'd0);
        check("async_valid", 32'(valid), 32'd0);
        #18 rst_n = 1'b1;
        m_x = 4'd0; m_y = 4'd0; m_valid = 1'b0; m_state = 2'b00;
        exp_q.delete();
        repeat (5) @(posedge clk);
        do_press(4'd6, 20);
        check_outputs("after_reset", 4'd6, 4'd0, 1'b0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
